// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth, run-time almost-full and
// almost-empty thresholds, an occupancy count, synchronous flush and a selectable
// first-word-fall-through read mode.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow
// flags and their clear input.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int FWFT       = 0,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic [FIFO_WIDTH-1:0] wr_data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [FIFO_WIDTH-1:0] rd_data_o,
    input  logic [CNT_WIDTH-1:0]  a_full_thr_i,
    input  logic [CNT_WIDTH-1:0]  a_empty_thr_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  a_full_o,
    output logic                  empty_o,
    output logic                  a_empty_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  underflow_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0]     PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  wr_en, rd_en;

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags come straight from the registered count; thresholds act combinationally.
    assign count_o   = count_q;
    assign full_o    = (count_q == CNT_DEPTH);
    assign empty_o   = (count_q == '0);
    assign a_full_o  = (count_q >= a_full_thr_i);
    assign a_empty_o = (count_q <= a_empty_thr_i);

    // Requests are qualified by the registered flags; flush overrides both.
    assign wr_en = push_i & ~full_o & ~flush_i;
    assign rd_en = pop_i & ~empty_o & ~flush_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;

            // Read register loads the head word only on an accepted pop.
            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_en) rd_data_d = mem_q[rd_ptr_q];
            end

            // Read data register.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) rd_data_q <= '0;
                else         rd_data_q <= rd_data_d;
            end

            assign rd_data_o = rd_data_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_comb begin
        ovf_d = (push_i & full_o)  | (ovf_q & ~err_clr_i);
        udf_d = (pop_i  & empty_o) | (udf_q & ~err_clr_i);
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read instance (depth 5, width 8) checked by a
// queue model plus read-data scoreboard, and a FWFT instance checked directly.
module tb_sync_fifo_prog;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic [CW-1:0] af_thr = CW'(4), ae_thr = CW'(1);
    logic [W-1:0]  rdata;
    logic [CW-1:0] count;
    logic          full, a_full, empty, a_empty;

    logic          f_push = 1'b0, f_pop = 1'b0;
    logic [W-1:0]  f_wdata = '0;
    logic [W-1:0]  f_rdata;
    logic [CW-1:0] f_count;
    logic          f_full, f_a_full, f_empty, f_a_empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic err_clr = 1'b0, ovf, udf, f_err_clr, f_ovf, f_udf;
    assign f_err_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mq [$];     // model of FIFO contents
    logic [W-1:0] exp_q [$];  // expected read words, consumed by the monitor
    logic [W-1:0] last_rd = '0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_std (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .wr_data_i(wdata),
        .push_i(push), .pop_i(pop), .rd_data_o(rdata),
        .a_full_thr_i(af_thr), .a_empty_thr_i(ae_thr), .count_o(count),
        .full_o(full), .a_full_o(a_full), .empty_o(empty), .a_empty_o(a_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr_i(err_clr), .overflow_o(ovf), .underflow_o(udf)
`endif
    );

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
        .clk_i(clk), .rstn_i(rstn), .flush_i(1'b0), .wr_data_i(f_wdata),
        .push_i(f_push), .pop_i(f_pop), .rd_data_o(f_rdata),
        .a_full_thr_i(af_thr), .a_empty_thr_i(ae_thr), .count_o(f_count),
        .full_o(f_full), .a_full_o(f_a_full), .empty_o(f_empty), .a_empty_o(f_a_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr_i(f_err_clr), .overflow_o(f_ovf), .underflow_o(f_udf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each accepted pop makes one registered read word available after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
    end

    task automatic check_status();
        int n;
        n = mq.size();
        chk("count",   32'(count),   32'(n));
        chk("full",    32'(full),    32'(n == D));
        chk("empty",   32'(empty),   32'(n == 0));
        chk("a_full",  32'(a_full),  32'(n >= int'(af_thr)));
        chk("a_empty", 32'(a_empty), 32'(n <= int'(ae_thr)));
    endtask

    // One clock of stimulus on the standard instance, model updated after the edge.
    task automatic cyc(input logic ps, input logic pp, input logic [W-1:0] d, input logic fl);
        logic we, re;
        push = ps; pop = pp; wdata = d; flush = fl;
        we = ps && (mq.size() < D);
        re = pp && (mq.size() > 0);
        @(posedge clk); #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (re) begin
                exp_q.push_back(mq[0]);
                last_rd = mq[0];
                void'(mq.pop_front());
            end
            if (we) mq.push_back(d);
        end
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        check_status();
    endtask

    task automatic fcyc(input logic ps, input logic pp, input logic [W-1:0] d);
        f_push = ps; f_pop = pp; f_wdata = d;
        @(posedge clk); #1;
        f_push = 1'b0; f_pop = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset values.
        chk("rst_count",   32'(count),   0);
        chk("rst_empty",   32'(empty),   1);
        chk("rst_a_empty", 32'(a_empty), 1);
        chk("rst_full",    32'(full),    0);
        chk("rst_a_full",  32'(a_full),  0);
        chk("rst_rdata",   32'(rdata),   0);
        chk("rst_f_rdata", 32'(f_rdata), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // FWFT instance: write into empty appears one clock later without a pop.
        fcyc(1'b1, 1'b0, 8'hA5);
        chk("fw_empty_fall", 32'(f_empty), 0);
        chk("fw_show_a5",    32'(f_rdata), 32'h A5);
        fcyc(1'b1, 1'b0, 8'hB6);
        chk("fw_hold_a5",    32'(f_rdata), 32'h A5);
        chk("fw_count2",     32'(f_count), 2);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_show_b6",    32'(f_rdata), 32'h B6);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_empty_rise", 32'(f_empty), 1);

        // Fill: 0x11..0x55.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, W'(i * 8'h11), 1'b0);

        // Push into full is dropped.
        cyc(1'b1, 1'b0, 8'h66, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(ovf), 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("overflow_clr", 32'(ovf), 0);
`endif

        // Full with push and pop: pop wins, 0x66 rejected.
        cyc(1'b1, 1'b1, 8'h66, 1'b0);
        chk("full_pushpop_cnt", 32'(count), 4);

        // Drain, then repeated fill/drain of varying length to walk pointers across the wrap.
        while (mq.size() > 0) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j <= (i % 5); j++) cyc(1'b1, 1'b0, W'(i * 16 + j + 1), 1'b0);
            while (mq.size() > 0) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Empty with push and pop: push accepted, pop rejected.
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        chk("empty_pushpop_cnt", 32'(count), 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("underflow_set", 32'(udf), 1);
`endif

        // Three words stored, pop then simultaneous push+pop keeps count at 3.
        cyc(1'b1, 1'b0, 8'h88, 1'b0);
        cyc(1'b1, 1'b0, 8'h99, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'hAA, 1'b0);
        cyc(1'b1, 1'b1, 8'hBB, 1'b0);
        chk("pushpop_cnt3", 32'(count), 3);

        // Run-time threshold change acts without a clock edge.
        af_thr = CW'(3); ae_thr = CW'(3);
        #1;
        chk("thr_a_full",  32'(a_full),  1);
        chk("thr_a_empty", 32'(a_empty), 1);
        af_thr = CW'(4); ae_thr = CW'(1);
        #1;
        chk("thr_a_full_back",  32'(a_full),  0);
        chk("thr_a_empty_back", 32'(a_empty), 0);

        // Flush with push: contents cleared, push ignored, read data held.
        cyc(1'b1, 1'b0, 8'hCC, 1'b1);
        chk("flush_cnt",   32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_rdata", 32'(rdata), 32'(last_rd));

        // Refill, then assert reset mid-stream between edges.
        cyc(1'b1, 1'b0, 8'hD1, 1'b0);
        cyc(1'b1, 1'b0, 8'hD2, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'hD3, 1'b0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        mq.delete();
        chk("arst_count",   32'(count),   0);
        chk("arst_empty",   32'(empty),   1);
        chk("arst_a_empty", 32'(a_empty), 1);
        chk("arst_full",    32'(full),    0);
        chk("arst_a_full",  32'(a_full),  0);
        chk("arst_rdata",   32'(rdata),   0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_status();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
